// File: rtl/wb_store_buffer_pkg.sv
// Shared pipeline package for the write-back store buffer: size encodings and default
// geometry. The optional load-forwarding feature is enabled with WB_STORE_FWD_EN.
package wb_store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_PA_W   = 15;
    localparam int SB_DATA_W = 32;

    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_3B = 2'b10;
    localparam logic [1:0] SZ_4B = 2'b11;

endpackage

// File: rtl/wb_fwd_select.sv
// Youngest-match priority selector for store-to-load forwarding (used under WB_STORE_FWD_EN).
// Inputs are age-ordered: index 0 is the oldest occupied slot, index N-1 the youngest.
module wb_fwd_select
    import wb_store_buffer_pkg::*;
#(
    parameter int N      = SB_DEPTH,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic [N-1:0]        match,
    input  logic [N*DATA_W-1:0] data_ord,
    input  logic [N*2-1:0]      size_ord,
    output logic                hit,
    output logic [DATA_W-1:0]   data,
    output logic [1:0]          size
);

    assign hit = |match;

    // Later (younger) matches overwrite earlier ones, so the last hit wins.
    always_comb begin
        data = '0;
        size = SZ_1B;
        for (int k = 0; k < N; k++) begin
            if (match[k]) begin
                data = data_ord[k*DATA_W +: DATA_W];
                size = size_ord[k*2 +: 2];
            end
        end
    end

endmodule

// File: rtl/wb_store_buffer.sv
// Write-back store buffer: in-order circular FIFO of stores drained to memory.
// Define WB_STORE_FWD_EN to add store-to-load forwarding ports.
module wb_store_buffer
    import wb_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int PA_W   = SB_PA_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq_v,
    input  logic [PA_W-1:0]        enq_pa,
    input  logic [DATA_W-1:0]      enq_data,
    input  logic [1:0]             enq_size,
    output logic                   stall,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   mem_wr_v,
    output logic [PA_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    output logic [1:0]             mem_size,
    input  logic                   mem_ack
`ifdef WB_STORE_FWD_EN
    ,
    input  logic                   ld_v,
    input  logic [PA_W-1:0]        ld_pa,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [1:0]             fwd_size
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr, rd_ptr;
    logic [AW:0]        wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic               enq_fire, deq_fire;
    logic [PA_W-1:0]    pa_mem   [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [1:0]         size_mem [DEPTH];

    // Handshakes: a store transfers on an edge where enq_v=1 and stall=0; the head transfers
    // on an edge where mem_wr_v=1 and mem_ack=1. A full buffer still accepts when the head leaves.
    assign deq_fire = ~empty & mem_ack;
    assign enq_fire = enq_v & (~full | mem_ack);
    assign stall    = enq_v & full & ~mem_ack;
    assign mem_wr_v = ~empty;

    assign mem_addr = pa_mem[rd_ptr[AW-1:0]];
    assign mem_data = data_mem[rd_ptr[AW-1:0]];
    assign mem_size = size_mem[rd_ptr[AW-1:0]];

    always_comb begin
        wr_ptr_nxt = wr_ptr + (AW+1)'(enq_fire);
        rd_ptr_nxt = rd_ptr + (AW+1)'(deq_fire);
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == (AW+1)'(DEPTH));
            empty  <= (count_nxt == '0);
        end
    end

    // Entry storage is deliberately left unreset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pa_mem[wr_ptr[AW-1:0]]   <= enq_pa;
            data_mem[wr_ptr[AW-1:0]] <= enq_data;
            size_mem[wr_ptr[AW-1:0]] <= enq_size;
        end
    end

`ifdef WB_STORE_FWD_EN
    logic [DEPTH-1:0]        fwd_match;
    logic [DEPTH*DATA_W-1:0] fwd_data_ord;
    logic [DEPTH*2-1:0]      fwd_size_ord;
    logic [AW-1:0]           slot;

    // Walk from the head so index k is the k-th oldest entry; only registered occupancy counts.
    always_comb begin
        fwd_match    = '0;
        fwd_data_ord = '0;
        fwd_size_ord = '0;
        slot         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr[AW-1:0] + AW'(k);
            fwd_match[k] = ld_v && (k < int'(count)) && (pa_mem[slot] == ld_pa);
            fwd_data_ord[k*DATA_W +: DATA_W] = data_mem[slot];
            fwd_size_ord[k*2 +: 2]           = size_mem[slot];
        end
    end

    wb_fwd_select #(
        .N      (DEPTH),
        .DATA_W (DATA_W)
    ) u_fwd_select (
        .match    (fwd_match),
        .data_ord (fwd_data_ord),
        .size_ord (fwd_size_ord),
        .hit      (fwd_hit),
        .data     (fwd_data),
        .size     (fwd_size)
    );
`endif

endmodule
